// File: rtl/instr_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage_if
// Bundles the fetch stage's program-counter, instruction-memory and
// downstream-handshake signals.
//   master : the fetch stage itself
//   slave  : the surroundings (program counter, imem, decode)
// Signals:
//   pc_in, pc_adv, redirect           program counter side
//   imem_en, imem_addr, imem_rdata    synchronous instruction memory
//   out_valid, out_ready,
//   out_instr, out_pc                 valid/ready output to decode
// -----------------------------------------------------------------------------
interface instr_fetch_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_adv;
  logic               redirect;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    input  pc_in, redirect, imem_rdata, out_ready,
    output pc_adv, imem_en, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output pc_in, redirect, imem_rdata, out_ready,
    input  pc_adv, imem_en, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Fetch stage between the program counter and instruction decode. In RUN it
// issues one read per cycle to a synchronous instruction memory whenever the
// 2-entry output buffer is guaranteed room for the answer, tags the returned
// word with its PC and presents the buffer head through valid/ready.
// A taken redirect flushes the buffer and discards any returning read.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   bus          instr_fetch_stage_if.master (pc_in/pc_adv/redirect,
//                imem_en/imem_addr/imem_rdata, out_valid/out_ready/
//                out_instr/out_pc)
//   fetch_count  (FETCH_STATS_EN) saturating count of buffer pushes
//   flush_count  (FETCH_STATS_EN) saturating count of redirects that
//                discarded buffered or in-flight work
//
// Build option: define FETCH_STATS_EN to add the two statistics outputs.
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_stage_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         flush_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  state_t            state_q, state_d;
  entry_t            buf_q [0:1];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] cap_addr_q;

  logic              pop;
  logic              push;
  logic              issue;
  logic              redirect_run;
  logic [2:0]        occupancy;

  assign pop          = bus.out_valid & bus.out_ready;
  assign redirect_run = (state_q == RUN) & bus.redirect;
  // A returning read is only dropped by a redirect in the same cycle.
  assign push         = inflight_q & ~redirect_run;
  // Slots committed after this edge: buffered + in flight - leaving now.
  // A pop implies count_q >= 1, so this never underflows.
  assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: state_d = RUN;  // one quiet cycle lets the PC settle
      RUN:  issue   = ~rst & ~bus.redirect & (occupancy < 3'd2);
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      cap_addr_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      // NOTE: the two buffer entries are reset because the head entry drives
      // out_instr/out_pc directly and those must read zero after reset.
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        cap_addr_q <= bus.pc_in;
      end
      if (redirect_run) begin
        count_q  <= 2'd0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          buf_q[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: cap_addr_q};
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign bus.imem_en   = issue;
  assign bus.pc_adv    = issue;
  assign bus.imem_addr = bus.pc_in;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = buf_q[rd_ptr_q].instr;
  assign bus.out_pc    = buf_q[rd_ptr_q].pc;

`ifdef FETCH_STATS_EN
  logic flush_hit;
  assign flush_hit = redirect_run & ((count_q != 2'd0) | inflight_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (push && fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (flush_hit && flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
// Drives instr_fetch_stage with a program-counter model and a synchronous
// memory model, and compares every cycle against a queue-based reference of
// the fetch stage. Directed sequences pin the reference with literal values,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instr_fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [7:0] a);
    return 32'hA000_0000 | {24'h0, a};
  endfunction

  // Reference model: buffer contents as a queue plus one pending read.
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } ent_t;

  ent_t        m_buf[$];
  bit          m_inflight;
  logic [7:0]  m_addr;
  bit          m_run;
  bit          m_known;
  bit          m_zero;
  int          m_fetch;
  int          m_flush;

  // Environment: program counter and memory read-data register.
  logic [7:0]  env_pc;
  logic [31:0] env_rdata;

  // Outputs sampled at the falling edge of the current cycle.
  logic        s_valid, s_en, s_adv;
  logic [31:0] s_instr;
  logic [7:0]  s_pc, s_addr;

  task automatic cycle(input bit r, input bit redir, input bit rdy, input logic [7:0] target);
    bit e_valid;
    bit e_pop;
    bit e_issue;
    bit flush_now;
    rst           = r;
    bus.redirect  = redir;
    bus.out_ready = rdy;
    bus.pc_in     = env_pc;
    bus.imem_rdata = env_rdata;
    @(negedge clk);
    s_valid = bus.out_valid;
    s_en    = bus.imem_en;
    s_adv   = bus.pc_adv;
    s_instr = bus.out_instr;
    s_pc    = bus.out_pc;
    s_addr  = bus.imem_addr;

    e_valid = 1'b0;
    e_pop   = 1'b0;
    e_issue = 1'b0;
    if (m_known) begin
      e_valid = (m_buf.size() != 0);
      e_pop   = e_valid && rdy;
      e_issue = !r && m_run && !redir &&
                (m_buf.size() + int'(m_inflight) - int'(e_pop) < 2);
      check("out_valid", 32'(s_valid), 32'(e_valid));
      if (e_valid) begin
        check("out_instr", s_instr, m_buf[0].instr);
        check("out_pc", 32'(s_pc), 32'(m_buf[0].pc));
      end else if (m_zero) begin
        check("out_instr_zero", s_instr, 32'h0);
        check("out_pc_zero", 32'(s_pc), 32'h0);
      end
      check("imem_en", 32'(s_en), 32'(e_issue));
      check("pc_adv", 32'(s_adv), 32'(e_issue));
      if (e_issue) check("imem_addr", 32'(s_addr), 32'(env_pc));
`ifdef FETCH_STATS_EN
      check("fetch_count", 32'(fetch_count), 32'(m_fetch));
      check("flush_count", 32'(flush_count), 32'(m_flush));
`endif
    end

    if (r) begin
      m_buf.delete();
      m_inflight = 1'b0;
      m_addr     = 8'h00;
      m_run      = 1'b0;
      m_zero     = 1'b1;
      m_fetch    = 0;
      m_flush    = 0;
      m_known    = 1'b1;
    end else if (m_known) begin
      flush_now = m_run && redir;
      if (flush_now && (m_buf.size() != 0 || m_inflight) && m_flush < 65535) m_flush++;
      if (e_pop) void'(m_buf.pop_front());
      if (flush_now) begin
        m_buf.delete();
      end else if (m_inflight) begin
        m_buf.push_back('{instr: mem_f(m_addr), pc: m_addr});
        m_zero = 1'b0;
        if (m_fetch < 65535) m_fetch++;
      end
      m_inflight = e_issue;
      m_addr     = env_pc;
      m_run      = 1'b1;
    end

    if (r || redir) env_pc = target;
    else if (s_adv) env_pc = env_pc + 8'd1;
    env_rdata = s_en ? mem_f(s_addr) : $urandom();

    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          r_rand, rd_rand, rdy_rand;
    logic [7:0]  tgt;
    rst            = 1'b1;
    bus.redirect   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.pc_in      = 8'h00;
    bus.imem_rdata = '0;
    env_pc         = 8'h00;
    env_rdata      = 32'h0;
    m_known        = 1'b0;
    m_zero         = 1'b1;
    m_inflight     = 1'b0;
    m_run          = 1'b0;
    m_fetch        = 0;
    m_flush        = 0;
    @(posedge clk);
    #1;

    // Reset for two cycles.
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    check("rst_valid", 32'(s_valid), 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_pc", 32'(s_pc), 32'h0);
    check("rst_en", 32'(s_en), 32'h0);

    // Streaming: first word three cycles after reset release, then no gaps.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      if (k == 0) check("idle_no_issue", 32'(s_en), 32'h0);
      if (k == 1) begin
        check("first_issue", 32'(s_en), 32'h1);
        check("first_addr", 32'(s_addr), 32'h0);
      end
      if (k == 2) check("latency_valid_low", 32'(s_valid), 32'h0);
      if (k >= 3) begin
        check("stream_valid", 32'(s_valid), 32'h1);
        check("stream_pc", 32'(s_pc), 32'(k - 3));
        check("stream_instr", s_instr, 32'hA000_0000 | 32'(k - 3));
      end
    end

    // Redirect to 0x40 during steady streaming.
    cycle(1'b0, 1'b1, 1'b1, 8'h40);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("redir_flush_valid", 32'(s_valid), 32'h0);
    check("redir_resume_issue", 32'(s_en), 32'h1);
    check("redir_resume_addr", 32'(s_addr), 32'h40);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("redir_gap", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("redir_target_valid", 32'(s_valid), 32'h1);
    check("redir_target_pc", 32'(s_pc), 32'h40);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("redir_next_pc", 32'(s_pc), 32'h41);

    // Reset mid-stream, then backpressure, then release.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b0, (k >= 8), 8'h00);
      if (k == 0) begin
        check("midrst_valid", 32'(s_valid), 32'h0);
        check("midrst_instr", s_instr, 32'h0);
        check("midrst_pc", 32'(s_pc), 32'h0);
        check("midrst_en", 32'(s_en), 32'h0);
      end
      if (k == 7) begin
        check("bp_valid", 32'(s_valid), 32'h1);
        check("bp_pc_stable", 32'(s_pc), 32'h0);
        check("bp_no_issue", 32'(s_en), 32'h0);
        check("bp_no_adv", 32'(s_adv), 32'h0);
      end
      if (k >= 8) begin
        check("release_pc", 32'(s_pc), 32'(k - 8));
        check("pushpop_issue", 32'(s_en), 32'h1);
      end
    end

    // PC wrap 0xFF -> 0x00 is tagged as the program counter presents it.
    cycle(1'b1, 1'b0, 1'b1, 8'hFE);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      if (k == 3) check("wrap_pc_fe", 32'(s_pc), 32'hFE);
      if (k == 4) check("wrap_pc_ff", 32'(s_pc), 32'hFF);
      if (k == 5) check("wrap_pc_00", 32'(s_pc), 32'h00);
    end

`ifdef FETCH_STATS_EN
    // Ten pushes, a flush with a full buffer, then a redirect with nothing
    // to discard.
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 13; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      if (k == 12) check("stats_fetch10", 32'(fetch_count), 32'd10);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h80);
    cycle(1'b0, 1'b1, 1'b0, 8'h80);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("stats_flush1", 32'(flush_count), 32'd1);
    check("stats_fetch12", 32'(fetch_count), 32'd12);
`endif

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      r_rand   = ($urandom_range(0, 199) == 0);
      rd_rand  = ($urandom_range(0, 19) == 0);
      rdy_rand = ($urandom_range(0, 9) < 7);
      tgt      = 8'($urandom());
      cycle(r_rand, rd_rand, rdy_rand, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
